// File: rtl/tdc_pkg.sv
// Shared types and helpers for the tapped-delay-line capture sequencer.
package tdc_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_CLEAR  = 3'd4,
        S_DONE   = 3'd5
    } tdc_state_t;

    localparam int DEFAULT_N_CELLS = 64;

    // Odd cells invert their output, so every second tap reads back inverted.
    localparam logic [DEFAULT_N_CELLS-1:0] DEFAULT_INV_MASK = {DEFAULT_N_CELLS/2{2'b10}};

    // Bits needed to hold a count of 0..n set taps.
    function automatic int calc_cw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tdc_popcount.sv
// Combinational population count of the corrected tap vector.
module tdc_popcount #(
    parameter int N  = 64,
    parameter int CW = 7
) (
    input  logic [N-1:0]  i_vec,
    output logic [CW-1:0] o_cnt
);

    logic [CW-1:0] w_cnt;

    // Plain ripple sum; counting ones rather than finding the first zero tolerates bubbles.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt = w_cnt + CW'(i_vec[i]);
        end
    end

    assign o_cnt = w_cnt;

endmodule

// File: rtl/tdc_capture_ctrl.sv
// Launch / settle / sample / drain sequencer for the delay line; accumulates
// 2^ACCUM_LOG2 shot counts and hands the sum out on a valid/ready port.
module tdc_capture_ctrl
    import tdc_pkg::*;
#(
    parameter int                  N_CELLS     = 64,
    parameter int                  SETTLE      = 3,
    parameter int                  ACCUM_LOG2  = 4,
    parameter int                  CLR_TIMEOUT = 255,
    parameter logic [N_CELLS-1:0]  INV_MASK    = {N_CELLS/2{2'b10}},
    localparam int                 CW          = calc_cw(N_CELLS),
    localparam int                 SW          = CW + ACCUM_LOG2
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_launch,
    input  logic [N_CELLS-1:0] i_q,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [SW-1:0]      o_sum,
    output logic               o_ovf,
    output logic               o_err
);

    localparam int WW  = $clog2(SETTLE + 1);
    localparam int CTW = $clog2(CLR_TIMEOUT + 1);

    // Result handshake: o_valid is held from DONE entry until a cycle with
    // i_ready high; the transfer happens on that edge and o_sum/o_ovf/o_err
    // stay constant while o_valid is high.

    tdc_state_t           r_state;
    tdc_state_t           w_next;
    logic                 r_launch;
    logic [WW-1:0]        r_wait;
    logic [CTW-1:0]       r_clr;
    logic [ACCUM_LOG2-1:0] r_shot;
    logic [SW-1:0]        r_acc;
    logic                 r_ovf;
    logic                 r_err;

    logic [N_CELLS-1:0]   w_code;
    logic [CW-1:0]        w_cnt;
    logic                 w_drained;
    logic                 w_full;
    logic                 w_timeout;
    logic                 w_clr_exit;
    logic                 w_last_shot;

    assign w_code      = i_q ^ INV_MASK;
    assign w_drained   = ~|w_code;
    assign w_full      = &w_code;
    assign w_timeout   = (r_clr == CTW'(CLR_TIMEOUT - 1));
    assign w_clr_exit  = w_drained || w_timeout;
    assign w_last_shot = &r_shot;

    tdc_popcount #(
        .N  (N_CELLS),
        .CW (CW)
    ) u_popcount (
        .i_vec (w_code),
        .o_cnt (w_cnt)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT:   if (r_wait == WW'(SETTLE - 1)) w_next = S_SAMPLE;
            S_SAMPLE: w_next = S_CLEAR;
            S_CLEAR:  if (w_clr_exit) w_next = w_last_shot ? S_DONE : S_LAUNCH;
            S_DONE:   if (i_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (r_state != S_IDLE);
        o_valid = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_launch <= 1'b0;
            r_wait   <= '0;
            r_clr    <= '0;
            r_shot   <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_launch <= 1'b1;
                        r_shot   <= '0;
                        r_acc    <= '0;
                        r_ovf    <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                S_LAUNCH: r_wait <= '0;
                S_WAIT:   r_wait <= r_wait + 1'b1;
                S_SAMPLE: begin
                    r_acc    <= r_acc + SW'(w_cnt);
                    r_launch <= 1'b0;
                    r_clr    <= '0;
                    if (w_full) r_ovf <= 1'b1;
                end
                S_CLEAR: begin
                    r_clr <= r_clr + 1'b1;
                    // A stuck line is flagged but the batch still completes.
                    if (w_clr_exit) begin
                        if (!w_drained) r_err <= 1'b1;
                        if (!w_last_shot) begin
                            r_shot   <= r_shot + 1'b1;
                            r_launch <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_launch = r_launch;
    assign o_sum    = r_acc;
    assign o_ovf    = r_ovf;
    assign o_err    = r_err;

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// Directed bench for tdc_capture_ctrl with a reactive delay-line model and a result scoreboard.
module tb_tdc_capture_ctrl;

    localparam int N  = 8;
    localparam int SW = 6;
    localparam int W  = SW + 2;

    logic          clk;
    logic          nrst;
    logic          i_start;
    logic          o_busy;
    logic          o_launch;
    logic [N-1:0]  i_q;
    logic          o_valid;
    logic          i_ready;
    logic [SW-1:0] o_sum;
    logic          o_ovf;
    logic          o_err;

    logic [N-1:0]  hit_pat;
    logic [N-1:0]  rest_pat;
    logic [W-1:0]  exp_q[$];
    int            n_tests;
    int            n_fail;

    tdc_capture_ctrl #(
        .N_CELLS     (8),
        .SETTLE      (3),
        .ACCUM_LOG2  (2),
        .CLR_TIMEOUT (255),
        .INV_MASK    (8'hAA)
    ) dut (
        .i_clk    (clk),
        .i_nrst   (nrst),
        .i_start  (i_start),
        .o_busy   (o_busy),
        .o_launch (o_launch),
        .i_q      (i_q),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sum    (o_sum),
        .o_ovf    (o_ovf),
        .o_err    (o_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Delay-line model: taps read the hit pattern while the launch edge is in flight.
    always @(negedge clk) begin
        i_q <= o_launch ? hit_pat : rest_pat;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops on every accepted result.
    always @(negedge clk) begin
        if (nrst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got sum %0d with no expected result", o_sum);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("sb_sum", int'(o_sum), int'(e[W-1:2]));
                check("sb_ovf", int'(o_ovf), int'(e[1]));
                check("sb_err", int'(o_err), int'(e[0]));
            end
        end
    end

    // driver: one batch, measures start-to-valid latency
    task automatic run_batch(input logic [N-1:0] hit, input logic [N-1:0] rest,
                             input int exp_lat, input logic [W-1:0] exp_word,
                             input logic rdy);
        int cyc;
        bit got;
        hit_pat  = hit;
        rest_pat = rest;
        i_ready  = rdy;
        exp_q.push_back(exp_word);
        @(negedge clk);
        i_start = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            @(posedge clk);
            #1;
            i_start = 1'b0;
            cyc++;
            if (o_valid) got = 1'b1;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL valid_timeout: no o_valid within %0d cycles", cyc);
        end else begin
            check("latency", cyc, exp_lat);
        end
        if (rdy) begin
            @(posedge clk);
            #1;
            check("valid_one_cycle", int'(o_valid), 0);
            check("idle_after_accept", int'(o_busy), 0);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        nrst     = 1'b0;
        i_start  = 1'b0;
        i_ready  = 1'b1;
        hit_pat  = 8'hAA;
        rest_pat = 8'hAA;
        i_q      = 8'hAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_launch", int'(o_launch), 0);
            check("idle_valid", int'(o_valid), 0);
            check("idle_busy", int'(o_busy), 0);
            check("idle_sum", int'(o_sum), 0);
        end

        // 4 shots x popcount 4 = 16
        run_batch(8'hAA ^ 8'h0F, 8'hAA, 25, {6'd16, 1'b0, 1'b0}, 1'b1);
        // all taps set every shot: 4 x 8 = 32, saturated
        run_batch(8'hAA ^ 8'hFF, 8'hAA, 25, {6'd32, 1'b1, 1'b0}, 1'b1);
        // bubble in the thermometer still counts 4 ones
        run_batch(8'hAA ^ 8'b0001_0111, 8'hAA, 25, {6'd16, 1'b0, 1'b0}, 1'b1);
        // line never drains: every CLEAR runs the full 255 cycles
        run_batch(8'h55, 8'h55, 4 * (5 + 255) + 1, {6'd32, 1'b1, 1'b1}, 1'b1);

        // backpressure in DONE
        run_batch(8'hAA ^ 8'h0F, 8'hAA, 25, {6'd16, 1'b0, 1'b0}, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            i_start = (k % 2 == 0);
            check("bp_valid", int'(o_valid), 1);
            check("bp_sum", int'(o_sum), 16);
            check("bp_launch", int'(o_launch), 0);
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check("bp_still_valid", int'(o_valid), 1);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_released_valid", int'(o_valid), 0);
        check("bp_released_busy", int'(o_busy), 0);
        repeat (3) begin
            @(negedge clk);
            check("bp_no_queued_start", int'(o_busy), 0);
        end

        // async reset in WAIT discards the batch
        hit_pat  = 8'hAA ^ 8'h0F;
        rest_pat = 8'hAA;
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_launch", int'(o_launch), 1);
        check("pre_reset_busy", int'(o_busy), 1);
        nrst = 1'b0;
        #1;
        check("reset_launch", int'(o_launch), 0);
        check("reset_busy", int'(o_busy), 0);
        check("reset_valid", int'(o_valid), 0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_reset_busy", int'(o_busy), 0);
            check("post_reset_sum", int'(o_sum), 0);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
